// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake, shift-add multiplier and registered flags.
// Define ALU_SEQ_DIV_EN to turn op 000 into an unsigned restoring divider (otherwise NOP).
module alu_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    input  logic                 cin,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic                 carry,
    output logic                 overflow,
    output logic                 zero
);
    localparam int unsigned RW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
    logic [2:0]         r_op, w_op_nxt;
    logic               r_cin, w_cin_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [RW-1:0]      r_acc, r_mcand, w_acc_nxt, w_mcand_nxt, w_acc_step;
    logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
    logic [RW-1:0]      w_result_nxt, w_res;
    logic               w_busy_nxt, w_done_nxt, w_carry_nxt, w_ovf_nxt, w_zero_nxt;
    logic               w_carry, w_ovf, w_long_op;
    logic [WIDTH:0]     w_usum, w_udiff;

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0]   r_rem, r_quo, w_rem_nxt, w_quo_nxt, w_rem_step, w_quo_step;
    logic [WIDTH:0]     w_rem_sh, w_rem_sub;
    logic               w_ge;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_b});
        w_rem_sub  = w_rem_sh - {1'b0, r_b};
        w_rem_step = w_ge ? WIDTH'(w_rem_sub) : WIDTH'(w_rem_sh);
        w_quo_step = {r_quo[WIDTH-2:0], w_ge};
    end

    assign w_long_op = (op == OP_MUL) || (op == OP_NOP);
`else
    assign w_long_op = (op == OP_MUL);
`endif

    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : RW'(0));
    assign w_usum     = {1'b0, r_a} + {1'b0, r_b} + (WIDTH+1)'(r_cin);
    assign w_udiff    = {1'b0, r_a} - {1'b0, r_b} - (WIDTH+1)'(r_cin);

    // Final result and flags for the latched operation.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_op)
            OP_NOP: begin
`ifdef ALU_SEQ_DIV_EN
                w_res = {w_rem_step, w_quo_step};
                w_ovf = (r_b == '0);
`endif
            end
            OP_ADD: begin
                w_res   = RW'(w_usum);
                w_carry = w_usum[WIDTH];
                w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_usum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = RW'(w_udiff[WIDTH-1:0]);
                w_carry = w_udiff[WIDTH];
                w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_udiff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_MUL: begin
                w_res = w_acc_step;
                w_ovf = (w_acc_step[RW-1:WIDTH] != '0);
            end
            OP_SHL:  w_res = RW'(r_a) << r_b;
            OP_SHR:  w_res = RW'(r_a >> r_b);
            OP_OR:   w_res = RW'(r_a | r_b);
            OP_AND:  w_res = RW'(r_a & r_b);
            default: w_res = '0;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_cin_nxt    = r_cin;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_result_nxt = result;
        w_busy_nxt   = busy;
        w_done_nxt   = 1'b0;
        w_carry_nxt  = carry;
        w_ovf_nxt    = overflow;
        w_zero_nxt   = zero;
`ifdef ALU_SEQ_DIV_EN
        w_rem_nxt    = r_rem;
        w_quo_nxt    = r_quo;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt      = a;
                    w_b_nxt      = b;
                    w_op_nxt     = op;
                    w_cin_nxt    = cin;
                    w_cnt_nxt    = w_long_op ? CNT_W'(WIDTH) : CNT_W'(1);
                    w_acc_nxt    = '0;
                    w_mcand_nxt  = RW'(a);
                    w_mplier_nxt = b;
`ifdef ALU_SEQ_DIV_EN
                    w_rem_nxt    = '0;
                    w_quo_nxt    = a;
`endif
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_EXEC;
                end
            end
            S_EXEC: begin
                w_cnt_nxt    = r_cnt - CNT_W'(1);
                w_acc_nxt    = w_acc_step;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
`ifdef ALU_SEQ_DIV_EN
                w_rem_nxt    = w_rem_step;
                w_quo_nxt    = w_quo_step;
`endif
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt  = S_IDLE;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_result_nxt = w_res;
                    w_carry_nxt  = w_carry;
                    w_ovf_nxt    = w_ovf;
                    w_zero_nxt   = (w_res == '0);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cin    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            r_rem    <= '0;
            r_quo    <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_op     <= w_op_nxt;
            r_cin    <= w_cin_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            result   <= w_result_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
            carry    <= w_carry_nxt;
            overflow <= w_ovf_nxt;
            zero     <= w_zero_nxt;
`ifdef ALU_SEQ_DIV_EN
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
`endif
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 4-bit lab ALU.
- Width is generic (WIDTH) and results are 2*WIDTH bits.
- Operations are launched with a start/busy/done handshake. Multiply is an iterative shift-add engine.
- Registered status flags are provided. Sits between operand/switch registers and the display/result path of the lab datapath.

Parameters:
- WIDTH, 4, operand width in bits (≥2); result width is 2*WIDTH; iteration counter sized $clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- init  input  1  reset, synchronous, active-high
- start  input  1  launch request; sampled only in IDLE
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B / shift amount, latched on accepted start
- op  input  3  operation code, latched on accepted start
- cin  input  1  carry/borrow in, latched on accepted start
- result  output  2*WIDTH  registered result, held until next completion
- busy  output  1  high while an operation executes
- done  output  1  one-cycle completion pulse
- carry  output  1  carry-out (ADD) / borrow-out (SUB), else 0
- overflow  output  1  signed overflow (ADD/SUB) or product exceeds WIDTH bits (MUL)
- zero  output  1  result == 0

Behaviour:
- Reset: init=1 at a clock edge forces state IDLE and result=0, busy=0, done=0, carry=0, overflow=0, zero=0, counter=0.
  - Reset aborts any operation in progress, including mid-MUL. No done pulse is produced for the aborted operation.
  - init has priority over start.
- FSM states: IDLE, EXEC.
  - IDLE: start=1 latches a, b, op, cin. Iteration count N is WIDTH for MUL and DIV, 1 otherwise. Transition to EXEC; busy=1 from the next cycle.
  - EXEC: runs N cycles. On the Nth edge the FSM writes result and flags, sets done=1 and busy=0, and returns to IDLE.
- Latency: start sampled at edge k → done high in the cycle after edge k+N.
  - Simple ops: 2 edges total.
  - MUL: WIDTH+1 edges total.
- done is high for exactly one cycle. During that cycle the FSM is in IDLE and accepts a new start, giving back-to-back operation.
- start while busy=1 is ignored: no relatch, no restart.
- result and flags change only on completion or reset. Operand input changes during EXEC have no effect.
- Operations (a, b unsigned unless noted; results zero-extended to 2*WIDTH):
  - 000 NOP: result=0, zero=1, other flags 0.
  - 001 ADD: {c,s}=a+b+cin; result={c,s}; carry=c; overflow=signed overflow of s.
  - 010 SUB: s=a-b-cin (mod 2^WIDTH); result=s; carry=1 iff a<b+cin; overflow=signed overflow.
  - 011 MUL: shift-add, one partial product per EXEC cycle, LSB of b first; result=a*b (2*WIDTH bits); overflow=(result[2W-1:W]!=0); carry=0.
  - 100 SHL: result=a<<b within 2*WIDTH bits; b≥2*WIDTH gives 0.
  - 101 SHR: result=a>>b; b≥WIDTH gives 0.
  - 110 OR, 111 AND: bitwise on WIDTH bits, zero-extended.
- Flag defaults: for ops 100, 101, 110 and 111, carry=0 and overflow=0.
- zero is always computed from the final 2*WIDTH result.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: op 000 becomes unsigned DIV, a restoring divider taking WIDTH EXEC cycles.
  - result={remainder, quotient}; carry=0; overflow=0.
  - b=0: quotient all ones, remainder=a, overflow=1. Still completes in WIDTH cycles.
- Undefined: op 000 is NOP as above. No divider logic is synthesised.

Test Plan:
- WIDTH=4; ADD a=9, b=8, cin=0 → done 2 edges after start; result=0x11, carry=1, overflow=1, zero=0.
- WIDTH=4; MUL a=15, b=15 → busy high 4 cycles, done on 5th edge; result=225 (0xE1), overflow=1. Then MUL 3*2 → result=6, overflow=0.
- WIDTH=4; SUB a=3, b=3, cin=0 → result=0, zero=1, carry=0. Then SUB 2-5 → result=0xD, carry=1.
- WIDTH=4; SHL a=0b1011, b=3 → result=0x58. SHR a=0b1011, b=5 → result=0, zero=1.
- Start MUL, pulse start with different operands at cycle 2 (ignored) and assert init at cycle 3 → all outputs 0, no done pulse. A fresh ADD 1+1 then yields result=2.
- ALU_SEQ_DIV_EN, WIDTH=4:
  - DIV 13/4 → result=0x13 after 4 EXEC cycles.
  - DIV 7/0 → result=0x7F, overflow=1.
